core101_mem_arbiter: RTL

Two-port arbiter that shares Core101's single external memory port between the instruction fetch path (port F, driven by the IFU/IFU control) and the data load/store path (port D). It sits between those requesters and the top-level memory pins. It serialises their transactions with a registered state machine and a round-robin tie-break. It returns read data and a one-cycle done pulse to the requester that owned the transaction.

---
 rtl/core101_mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/core101_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between fetch (F) and data (D).
// Optional build macro MEM_ARB_TIMEOUT_EN adds a BUSY watchdog with sticky err_out.
module core101_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              f_req_in,
  input  logic [ADDR_W-1:0] f_addr_in,
  output logic              f_done_out,
  output logic [DATA_W-1:0] f_rdata_out,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [DATA_W-1:0] d_wdata_in,
  output logic              d_done_out,
  output logic [DATA_W-1:0] d_rdata_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  input  logic              mem_valid_in,
  output logic              err_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_F = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              f_done_q, f_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_f, grant_d;
  logic              busy;
  logic              timeout_hit;

  assign busy = (state_q == BUSY_F) || (state_q == BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter is zero on the grant edge, so it reads N-1 during the N-th BUSY cycle.
  assign timeout_hit = busy && !mem_valid_in && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = busy ? cnt_q + 1'b1 : '0;
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_out     = 1'b0;
`endif

  // D wins a tie unless it was the last port served.
  assign grant_d = d_req_in && (!f_req_in || !last_d_q);
  assign grant_f = f_req_in && !grant_d;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    f_done_d  = 1'b0;
    d_done_d  = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY_D;
          addr_d  = d_addr_in;
          we_d    = d_we_in;
          wdata_d = d_wdata_in;
        end else if (grant_f) begin
          state_d = BUSY_F;
          addr_d  = f_addr_in;
          we_d    = 1'b0;
        end
      end
      BUSY_F: begin
        if (mem_valid_in) begin
          f_rdata_d = mem_rdata_in;
          f_done_d  = 1'b1;
          last_d_d  = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          f_rdata_d = '0;
          f_done_d  = 1'b1;
          last_d_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_valid_in) begin
          if (!we_q) d_rdata_d = mem_rdata_in;
          d_done_d = 1'b1;
          last_d_d = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          d_rdata_d = '0;
          d_done_d  = 1'b1;
          last_d_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      f_done_q  <= f_done_d;
      d_done_q  <= d_done_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Strobes decode the registered state, so an async reset drops them immediately.
  assign mem_read_out  = (state_q == BUSY_F) || ((state_q == BUSY_D) && !we_q);
  assign mem_write_out = (state_q == BUSY_D) && we_q;
  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign f_done_out    = f_done_q;
  assign d_done_out    = d_done_q;
  assign f_rdata_out   = f_rdata_q;
  assign d_rdata_out   = d_rdata_q;

endmodule
